dm_dmi_arbiter: RTL and testbench

- Shares one DMI target (the debug module's dmi_req_t/dmi_resp_t port) between NrMasters DMI requesters, e.g. the JTAG DTM and an on-chip debug host.
- Round-robin arbitration with one transaction outstanding at a time.
- Optional per-master lock keeps ownership across multi-access sequences such as an SBData0 burst or a Command plus Data0 read.
- Routes each response to the master that issued the request.

---
 rtl/dm_dmi_arbiter.sv | 167 ++++++++++++++++
 tb/tb_dm_dmi_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_dmi_arbiter.sv
// dm_dmi_arbiter
//   Shares one debug-module DMI target between NrMasters DMI requesters
//   (for example the JTAG DTM and an on-chip debug host). Only one
//   transaction is outstanding at a time. Arbitration is round-robin. A
//   master may hold ownership across several accesses by keeping its lock
//   input high. Each response goes back to the master that issued the
//   request.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   mst_req_valid_i     per-master request valid
//   mst_req_ready_o     per-master request accepted (one-hot or zero)
//   mst_req_i           per-master dmi_req_t {addr[6:0], op[1:0], data[31:0]}
//   mst_lock_i          per-master ownership lock
//   mst_resp_valid_o    per-master response valid (one-hot or zero)
//   mst_resp_ready_i    per-master response ready
//   mst_resp_o          shared dmi_resp_t {data[31:0], resp[1:0]}
//   slv_req_valid_o/ready_i/slv_req_o     registered request towards the DM
//   slv_resp_valid_i/ready_o/slv_resp_i   response from the DM
//   owner_o             index of the current or last owner
//   busy_o              a transaction is in flight
//   stray_resp_o        one-cycle pulse: a DM response was dropped while idle
//
// Handshake rule for every valid/ready pair: a transfer happens on a rising
// clock edge where valid and ready are both 1. Once valid is raised, the
// payload stays stable until the transfer. The master request is captured at
// acceptance and is not read again.

module dm_dmi_arbiter #(
  parameter  int NrMasters = 2,
  localparam int IdxW      = $clog2(NrMasters)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NrMasters-1:0]           mst_req_valid_i,
  output logic [NrMasters-1:0]           mst_req_ready_o,
  input  logic [NrMasters-1:0][40:0]     mst_req_i,
  input  logic [NrMasters-1:0]           mst_lock_i,
  output logic [NrMasters-1:0]           mst_resp_valid_o,
  input  logic [NrMasters-1:0]           mst_resp_ready_i,
  output logic [33:0]                    mst_resp_o,
  output logic                           slv_req_valid_o,
  input  logic                           slv_req_ready_i,
  output logic [40:0]                    slv_req_o,
  input  logic                           slv_resp_valid_i,
  output logic                           slv_resp_ready_o,
  input  logic [33:0]                    slv_resp_i,
  output logic [IdxW-1:0]                owner_o,
  output logic                           busy_o,
  output logic                           stray_resp_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e            state_q;
  logic [IdxW-1:0]   rr_ptr_q;
  logic [IdxW-1:0]   owner_q;
  logic              lock_q;
  logic [40:0]       slv_req_q;
  logic              stray_q;

  logic [IdxW-1:0]   winner;
  logic              win_valid;
  logic              lock_hold;
  logic [IdxW-1:0]   rr_next;

  // Winner selection. A held lock only counts while the owner still drives
  // its lock input, so arbitration resumes in the very cycle the lock drops.
  always_comb begin : pick
    int idx;
    idx       = 0;
    winner    = '0;
    win_valid = 1'b0;
    lock_hold = lock_q && mst_lock_i[owner_q];
    if (lock_hold) begin
      winner    = owner_q;
      win_valid = mst_req_valid_i[owner_q];
    end else begin
      for (int i = 0; i < NrMasters; i++) begin
        idx = int'(rr_ptr_q) + i;
        if (idx >= NrMasters) idx = idx - NrMasters;
        if (!win_valid && mst_req_valid_i[IdxW'(idx)]) begin
          winner    = IdxW'(idx);
          win_valid = 1'b1;
        end
      end
    end
  end

  // The master just served gets the lowest priority next time.
  assign rr_next = (winner == IdxW'(NrMasters - 1)) ? '0 : winner + 1'b1;

  // Handshake and response routing, decoded from the state.
  always_comb begin
    mst_req_ready_o  = '0;
    mst_resp_valid_o = '0;
    mst_resp_o       = '0;
    slv_resp_ready_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_valid) mst_req_ready_o[winner] = 1'b1;
        // Nothing is outstanding, so any DM response here is stray: drain it.
        slv_resp_ready_o = 1'b1;
      end
      RESP: begin
        mst_resp_o                = slv_resp_i;
        mst_resp_valid_o[owner_q] = slv_resp_valid_i;
        slv_resp_ready_o          = mst_resp_ready_i[owner_q];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      owner_q   <= '0;
      lock_q    <= 1'b0;
      slv_req_q <= '0;
      stray_q   <= 1'b0;
    end else begin
      stray_q <= (state_q == IDLE) && slv_resp_valid_i;
      case (state_q)
        IDLE: begin
          if (lock_q && !mst_lock_i[owner_q]) lock_q <= 1'b0;
          if (win_valid) begin
            slv_req_q <= mst_req_i[winner];
            owner_q   <= winner;
            rr_ptr_q  <= rr_next;
            state_q   <= REQ;
          end
        end
        REQ: begin
          if (slv_req_ready_i) state_q <= RESP;
        end
        RESP: begin
          if (slv_resp_valid_i && mst_resp_ready_i[owner_q]) begin
            lock_q  <= mst_lock_i[owner_q];
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign slv_req_valid_o = (state_q == REQ);
  assign slv_req_o       = slv_req_q;
  assign owner_o         = owner_q;
  assign busy_o          = (state_q != IDLE);
  assign stray_resp_o    = stray_q;

  a_req_stable : assert property (@(posedge clk_i) disable iff (rst_i)
    (slv_req_valid_o && !slv_req_ready_i) |=> $stable(slv_req_o));
  a_req_ready_onehot : assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(mst_req_ready_o));
  a_resp_valid_onehot : assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(mst_resp_valid_o));
  a_owner_range : assert property (@(posedge clk_i) disable iff (rst_i)
    int'(owner_o) < NrMasters);

endmodule

// File: tb/tb_dm_dmi_arbiter.sv
// Directed bench for dm_dmi_arbiter: a two-master instance carries most
// scenarios, and a three-master instance sharing the same slave stub checks
// round-robin order. Inputs change on the falling edge; outputs are sampled
// 1 ns later, well away from the rising edge.

module tb_dm_dmi_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // shared slave-side stimulus
  logic        slv_req_ready;
  logic        slv_resp_valid;
  logic [33:0] slv_resp;

  // two-master instance
  logic [1:0]       mv2, mlock2, mresp_rdy2;
  logic [1:0][40:0] mreq2;
  logic [1:0]       mrdy2, mrv2;
  logic [33:0]      mresp2;
  logic             sreq_valid2, sresp_ready2, busy2, stray2;
  logic [40:0]      sreq2;
  logic [0:0]       owner2;

  // three-master instance
  logic [2:0]       mv3, mlock3, mresp_rdy3;
  logic [2:0][40:0] mreq3;
  logic [2:0]       mrdy3, mrv3;
  logic [33:0]      mresp3;
  logic             sreq_valid3, sresp_ready3, busy3, stray3;
  logic [40:0]      sreq3;
  logic [1:0]       owner3;

  dm_dmi_arbiter #(.NrMasters(2)) dut2 (
    .clk_i(clk), .rst_i(rst),
    .mst_req_valid_i(mv2), .mst_req_ready_o(mrdy2), .mst_req_i(mreq2),
    .mst_lock_i(mlock2), .mst_resp_valid_o(mrv2), .mst_resp_ready_i(mresp_rdy2),
    .mst_resp_o(mresp2),
    .slv_req_valid_o(sreq_valid2), .slv_req_ready_i(slv_req_ready), .slv_req_o(sreq2),
    .slv_resp_valid_i(slv_resp_valid), .slv_resp_ready_o(sresp_ready2), .slv_resp_i(slv_resp),
    .owner_o(owner2), .busy_o(busy2), .stray_resp_o(stray2)
  );

  dm_dmi_arbiter #(.NrMasters(3)) dut3 (
    .clk_i(clk), .rst_i(rst),
    .mst_req_valid_i(mv3), .mst_req_ready_o(mrdy3), .mst_req_i(mreq3),
    .mst_lock_i(mlock3), .mst_resp_valid_o(mrv3), .mst_resp_ready_i(mresp_rdy3),
    .mst_resp_o(mresp3),
    .slv_req_valid_o(sreq_valid3), .slv_req_ready_i(slv_req_ready), .slv_req_o(sreq3),
    .slv_resp_valid_i(slv_resp_valid), .slv_resp_ready_o(sresp_ready3), .slv_resp_i(slv_resp),
    .owner_o(owner3), .busy_o(busy3), .stray_resp_o(stray3)
  );

  function automatic logic [40:0] mk_req(input logic [6:0] addr, input logic [1:0] op,
                                         input logic [31:0] data);
    return {addr, op, data};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    mv2 = '0; mlock2 = '0; mresp_rdy2 = 2'b11; mreq2 = '0;
    mv3 = '0; mlock3 = '0; mresp_rdy3 = 3'b111; mreq3 = '0;
    slv_req_ready = 1'b0; slv_resp_valid = 1'b0; slv_resp = '0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Starts and ends on a falling edge. Waits (bounded) for a grant on the
  // selected instance, then plays an always-ready slave: 3 cycles per access.
  task automatic serve_txn(input bit sel3, output int who, output logic [40:0] fwd,
                           output bit timeout);
    logic [2:0] g;
    timeout = 1'b1;
    who     = -1;
    fwd     = '0;
    for (int i = 0; i < 40; i++) begin
      #1;
      g = sel3 ? mrdy3 : {1'b0, mrdy2};
      if (g != 3'b000) begin
        timeout = 1'b0;
        who = g[2] ? 2 : (g[1] ? 1 : 0);
        break;
      end
      @(negedge clk);
    end
    if (!timeout) begin
      @(negedge clk);
      fwd = sel3 ? sreq3 : sreq2;
      slv_req_ready = 1'b1;
      @(negedge clk);
      slv_req_ready  = 1'b0;
      slv_resp_valid = 1'b1;
      slv_resp       = {32'h1234_5678, 2'b00};
      @(negedge clk);
      slv_resp_valid = 1'b0;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy2); end
    checks++; if (sreq_valid2 !== 1'b0) begin errors++; $display("FAIL reset_slv_req_valid got %b want 0", sreq_valid2); end
    checks++; if (sresp_ready2 !== 1'b1) begin errors++; $display("FAIL reset_slv_resp_ready got %b want 1", sresp_ready2); end
    checks++; if (mrdy2 !== 2'b00) begin errors++; $display("FAIL reset_mst_req_ready got %b want 00", mrdy2); end
    checks++; if (mrv2 !== 2'b00) begin errors++; $display("FAIL reset_mst_resp_valid got %b want 00", mrv2); end
    checks++; if (owner2 !== 1'b0) begin errors++; $display("FAIL reset_owner got %0d want 0", owner2); end
    checks++; if (sreq2 !== 41'd0) begin errors++; $display("FAIL reset_slv_req got %h want 0", sreq2); end
    checks++; if (mresp2 !== 34'd0) begin errors++; $display("FAIL reset_mst_resp got %h want 0", mresp2); end
    checks++; if (stray2 !== 1'b0) begin errors++; $display("FAIL reset_stray got %b want 0", stray2); end
    checks++; if (busy3 !== 1'b0 || owner3 !== 2'd0) begin errors++; $display("FAIL reset_dut3 got busy=%b owner=%0d want 0/0", busy3, owner3); end
  endtask

  task automatic test_single_read();
    logic [40:0] r;
    do_reset();
    r = mk_req(7'h11, 2'd1, 32'h0);
    mv2 = 2'b01; mreq2[0] = r;
    #1;
    checks++; if (mrdy2 !== 2'b01) begin errors++; $display("FAIL single_grant got %b want 01", mrdy2); end
    checks++; if (sreq_valid2 !== 1'b0) begin errors++; $display("FAIL single_valid_early got %b want 0", sreq_valid2); end
    @(negedge clk);
    mv2 = 2'b00; mreq2[0] = '0;
    #1;
    checks++; if (sreq_valid2 !== 1'b1) begin errors++; $display("FAIL single_req_latency got %b want 1", sreq_valid2); end
    checks++; if (sreq2 !== r) begin errors++; $display("FAIL single_req_data got %h want %h", sreq2, r); end
    checks++; if (busy2 !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", busy2); end
    slv_req_ready = 1'b1;
    @(negedge clk);
    slv_req_ready = 1'b0;
    slv_resp_valid = 1'b1; slv_resp = {32'h0040_0C82, 2'b00};
    #1;
    checks++; if (mrv2 !== 2'b01) begin errors++; $display("FAIL single_resp_valid got %b want 01", mrv2); end
    checks++; if (mresp2 !== {32'h0040_0C82, 2'b00}) begin errors++; $display("FAIL single_resp_data got %h want %h", mresp2, {32'h0040_0C82, 2'b00}); end
    @(negedge clk);
    slv_resp_valid = 1'b0;
    #1;
    checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL single_busy_after got %b want 0", busy2); end
    checks++; if (owner2 !== 1'b0) begin errors++; $display("FAIL single_owner got %0d want 0", owner2); end
    checks++; if (stray2 !== 1'b0) begin errors++; $display("FAIL single_no_stray got %b want 0", stray2); end
  endtask

  task automatic test_contention();
    int who, prev;
    bit to;
    logic [40:0] fwd;
    do_reset();
    mreq2[0] = mk_req(7'h04, 2'd1, 32'h0000_00A0);
    mreq2[1] = mk_req(7'h05, 2'd2, 32'h0000_00B1);
    mv2 = 2'b11;
    prev = -1;
    for (int i = 0; i < 8; i++) begin
      serve_txn(1'b0, who, fwd, to);
      checks++;
      if (to) begin errors++; $display("FAIL contention_timeout txn %0d no grant", i); end
      else if (who !== (i % 2)) begin errors++; $display("FAIL contention_order txn %0d got %0d want %0d", i, who, i % 2); end
      checks++;
      if (!to && (who == prev || fwd !== mreq2[i % 2])) begin
        errors++; $display("FAIL contention_fwd txn %0d got who=%0d req=%h want req=%h", i, who, fwd, mreq2[i % 2]);
      end
      prev = who;
    end
    mv2 = 2'b00;
  endtask

  task automatic test_lock();
    int who;
    bit to;
    logic [40:0] fwd, cmd, rd;
    do_reset();
    cmd = mk_req(7'h17, 2'd2, 32'h0022_1000);
    rd  = mk_req(7'h04, 2'd1, 32'h0);
    mlock2 = 2'b10; mv2 = 2'b10; mreq2[1] = cmd;
    mreq2[0] = mk_req(7'h10, 2'd1, 32'h0);
    serve_txn(1'b0, who, fwd, to);
    checks++; if (to || who !== 1 || fwd !== cmd) begin errors++; $display("FAIL lock_cmd got who=%0d req=%h want 1 %h", who, fwd, cmd); end
    mreq2[1] = rd; mv2 = 2'b11;
    serve_txn(1'b0, who, fwd, to);
    checks++; if (to || who !== 1 || fwd !== rd) begin errors++; $display("FAIL lock_data0 got who=%0d req=%h want 1 %h", who, fwd, rd); end
    mv2 = 2'b01;
    #1;
    checks++; if (mrdy2 !== 2'b00) begin errors++; $display("FAIL lock_stall1 got %b want 00", mrdy2); end
    @(negedge clk);
    #1;
    checks++; if (mrdy2 !== 2'b00) begin errors++; $display("FAIL lock_stall2 got %b want 00", mrdy2); end
    mlock2 = 2'b00;
    #1;
    checks++; if (mrdy2 !== 2'b01) begin errors++; $display("FAIL lock_release_grant got %b want 01", mrdy2); end
    serve_txn(1'b0, who, fwd, to);
    checks++; if (to || who !== 0) begin errors++; $display("FAIL lock_m0_served got %0d want 0", who); end
    mv2 = 2'b00;
  endtask

  task automatic test_backpressure();
    logic [40:0] r;
    int delivered;
    bit stable_ok, follow_ok;
    do_reset();
    r = mk_req(7'h3C, 2'd2, 32'hDEAD_BEEF);
    mv2 = 2'b01; mreq2[0] = r;
    #1;
    checks++; if (mrdy2 !== 2'b01) begin errors++; $display("FAIL bp_grant got %b want 01", mrdy2); end
    @(negedge clk);
    mv2 = 2'b00; mreq2[0] = 41'h1_FFFF_FFFF_FF;
    stable_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (sreq_valid2 !== 1'b1 || sreq2 !== r) stable_ok = 1'b0;
      @(negedge clk);
    end
    #1;
    checks++; if (!stable_ok || sreq2 !== r) begin errors++; $display("FAIL bp_req_stable got %h want %h", sreq2, r); end
    slv_req_ready = 1'b1;
    @(negedge clk);
    slv_req_ready = 1'b0;
    slv_resp_valid = 1'b1; slv_resp = {32'h0000_0055, 2'b10};
    mresp_rdy2 = 2'b10;
    delivered = 0; follow_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (sresp_ready2 !== 1'b0 || mrv2 !== 2'b01) follow_ok = 1'b0;
      if (mrv2[0] && mresp_rdy2[0]) delivered++;
      @(negedge clk);
    end
    mresp_rdy2 = 2'b11;
    #1;
    checks++; if (!follow_ok || sresp_ready2 !== 1'b1) begin errors++; $display("FAIL bp_resp_ready_follow got %b want 1", sresp_ready2); end
    if (mrv2[0] && mresp_rdy2[0]) delivered++;
    @(negedge clk);
    slv_resp_valid = 1'b0;
    #1;
    if (mrv2[0] && mresp_rdy2[0]) delivered++;
    checks++; if (delivered !== 1) begin errors++; $display("FAIL bp_delivered got %0d want 1", delivered); end
    checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL bp_idle_after got %b want 0", busy2); end
  endtask

  task automatic test_reset_mid();
    int who, strays;
    bit to;
    logic [40:0] fwd, r;
    do_reset();
    r = mk_req(7'h38, 2'd1, 32'h0);
    mv2 = 2'b01; mreq2[0] = r;
    @(negedge clk);
    mv2 = 2'b00;
    slv_req_ready = 1'b1;
    @(negedge clk);
    slv_req_ready = 1'b0;
    #1;
    checks++; if (busy2 !== 1'b1 || sresp_ready2 !== 1'b1) begin errors++; $display("FAIL rstmid_in_resp got busy=%b rdy=%b want 1 1", busy2, sresp_ready2); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL rstmid_abandon got busy=%b want 0", busy2); end
    strays = 0;
    @(negedge clk);
    @(negedge clk);
    slv_resp_valid = 1'b1; slv_resp = {32'hBAD0_0001, 2'b00};
    #1;
    checks++; if (mrv2 !== 2'b00) begin errors++; $display("FAIL rstmid_no_resp got %b want 00", mrv2); end
    @(negedge clk);
    slv_resp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (stray2 === 1'b1) strays++;
      @(negedge clk);
    end
    checks++; if (strays !== 1) begin errors++; $display("FAIL rstmid_stray_pulses got %0d want 1", strays); end
    mv2 = 2'b01; mreq2[0] = r;
    serve_txn(1'b0, who, fwd, to);
    checks++; if (to || who !== 0 || fwd !== r) begin errors++; $display("FAIL rstmid_next got who=%0d req=%h want 0 %h", who, fwd, r); end
    mv2 = 2'b00;
  endtask

  task automatic test_three_masters();
    int who;
    bit to;
    logic [40:0] fwd;
    int exp_order[4] = '{2, 0, 1, 2};
    do_reset();
    for (int m = 0; m < 3; m++) mreq3[m] = mk_req(7'(8'h20 + m), 2'd1, 32'(m));
    mv3 = 3'b010;
    serve_txn(1'b1, who, fwd, to);
    checks++; if (to || who !== 1) begin errors++; $display("FAIL rr3_setup got %0d want 1", who); end
    mv3 = 3'b111;
    for (int i = 0; i < 4; i++) begin
      serve_txn(1'b1, who, fwd, to);
      checks++;
      if (to || who !== exp_order[i] || fwd !== mreq3[exp_order[i]]) begin
        errors++; $display("FAIL rr3_order txn %0d got %0d want %0d", i, who, exp_order[i]);
      end
    end
    mv3 = 3'b000;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_lock();
    test_backpressure();
    test_reset_mid();
    test_three_masters();
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
